// File: rtl/ifft4_stream_pkg.sv
// Shared constants and types for the 4-point streaming IFFT.
// Complex words are {re, im}, each a signed CW-bit field.
package ifft4_stream_pkg;

  localparam int CW_DEF = 8;

  localparam logic [15:0] W4_0 = 16'h0100;
  localparam logic [15:0] W4_1 = 16'h00FF;
  localparam logic [15:0] W4_2 = 16'hFF00;
  localparam logic [15:0] W4_3 = 16'h0001;

  typedef enum logic [1:0] {
    LOAD   = 2'd0,
    CALC   = 2'd1,
    UNLOAD = 2'd2
  } state_t;

endpackage

// File: rtl/ifft4_stream_core.sv
// Combinational 4-point IFFT butterfly: add/sub, j-rotation, optional /4.
// Sums are carried at CW+2 bits so the exact result is always representable.
module ifft4_stream_core #(
  parameter int CW    = 8,
  parameter int SCALE = 1
) (
  input  logic [3:0][2*CW-1:0] xk,
  output logic [3:0][2*CW-1:0] xn
);

  localparam int W = CW + 2;

  logic signed [W-1:0] a [4];
  logic signed [W-1:0] b [4];
  logic signed [W-1:0] re [4];
  logic signed [W-1:0] im [4];

  always_comb begin
    for (int k = 0; k < 4; k++) begin
      a[k] = {{2{xk[k][2*CW-1]}}, xk[k][2*CW-1:CW]};
      b[k] = {{2{xk[k][CW-1]}}, xk[k][CW-1:0]};
    end
  end

  // j*(a+jb) = -b + ja
  always_comb begin
    re[0] = a[0] + a[1] + a[2] + a[3];
    im[0] = b[0] + b[1] + b[2] + b[3];
    re[1] = a[0] - b[1] - a[2] + b[3];
    im[1] = b[0] + a[1] - b[2] - a[3];
    re[2] = a[0] - a[1] + a[2] - a[3];
    im[2] = b[0] - b[1] + b[2] - b[3];
    re[3] = a[0] + b[1] - a[2] - b[3];
    im[3] = b[0] - a[1] - b[2] + a[3];
  end

  // Taking bits [CW+1:2] is the low CW bits of an arithmetic >>>2
  always_comb begin
    for (int n = 0; n < 4; n++) begin
      xn[n] = (SCALE != 0)
        ? {re[n][CW+1:2], im[n][CW+1:2]}
        : {re[n][CW-1:0], im[n][CW-1:0]};
    end
  end

endmodule

// File: rtl/ifft4_stream.sv
// Streaming 4-point IFFT: buffer X0..X3, compute in one cycle,
// then stream x0..x3 out; input stalls while results drain.
module ifft4_stream
  import ifft4_stream_pkg::*;
#(
  parameter int CW    = CW_DEF,
  parameter int SCALE = 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [2*CW-1:0] in_data,
  input  logic          in_last,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [2*CW-1:0] out_data,
  output logic          out_last,
  output logic          frame_err
);

  state_t state, nxt;

  logic [1:0] icnt, ocnt;
  logic [3:0][2*CW-1:0] bufr, res, calc;
  logic in_hs, out_hs;

  assign in_hs  = in_valid & in_ready;
  assign out_hs = out_valid & out_ready;

  ifft4_stream_core #(
    .CW   (CW),
    .SCALE(SCALE)
  ) u_core (
    .xk(bufr),
    .xn(calc)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= LOAD;
    else     state <= nxt;
  end

  always_comb begin
    nxt = state;
    unique case (state)
      LOAD:   if (in_hs && icnt == 2'd3) nxt = CALC;
      CALC:   nxt = UNLOAD;
      UNLOAD: if (out_hs && ocnt == 2'd3) nxt = LOAD;
      default: nxt = LOAD;
    endcase
  end

  always_comb begin
    in_ready  = (state == LOAD) & ~rst;
    out_valid = (state == UNLOAD);
    out_last  = out_valid & (ocnt == 2'd3);
    out_data  = out_valid ? res[ocnt] : '0;
  end

  // Counters wrap to 0 on the frame's final handshake
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      icnt      <= '0;
      ocnt      <= '0;
      bufr      <= '0;
      res       <= '0;
      frame_err <= 1'b0;
    end else begin
      frame_err <= 1'b0;
      if (in_hs) begin
        bufr[icnt] <= in_data;
        icnt       <= icnt + 2'd1;
        frame_err  <= in_last != (icnt == 2'd3);
      end
      if (state == CALC) res <= calc;
      if (out_hs) ocnt <= ocnt + 2'd1;
    end
  end

endmodule

// File: tb/tb_ifft4_stream.sv
// Bench for ifft4_stream: directed and random frames on SCALE=1 and
// SCALE=0 instances, checked against a direct DFT-sum model.
module tb_ifft4_stream;

  typedef logic [15:0] frame_t [4];

  logic clk = 1'b0;
  logic rst;
  logic in_valid, in_last, out_ready;
  logic [15:0] in_data;

  logic i_ready1, o1_valid, o1_last, o1_ferr;
  logic [15:0] o1_data;
  logic i_ready0, o0_valid, o0_last, o0_ferr;
  logic [15:0] o0_data;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  ifft4_stream #(.CW(8), .SCALE(1)) d1 (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(i_ready1),
    .in_data(in_data), .in_last(in_last),
    .out_valid(o1_valid), .out_ready(out_ready),
    .out_data(o1_data), .out_last(o1_last),
    .frame_err(o1_ferr)
  );

  ifft4_stream #(.CW(8), .SCALE(0)) d0 (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(i_ready0),
    .in_data(in_data), .in_last(in_last),
    .out_valid(o0_valid), .out_ready(out_ready),
    .out_data(o0_data), .out_last(o0_last),
    .frame_err(o0_ferr)
  );

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // x[n] = (1/4) * sum_k X[k] * j^(n*k)
  function automatic logic [15:0] ref_x(input frame_t x, input int n,
                                        input int scale);
    int sr, si, a, b, t;
    logic [15:0] r;
    sr = 0;
    si = 0;
    for (int k = 0; k < 4; k++) begin
      a = int'($signed(x[k][15:8]));
      b = int'($signed(x[k][7:0]));
      case ((n * k) % 4)
        0: begin sr += a; si += b; end
        1: begin sr -= b; si += a; end
        2: begin sr -= a; si -= b; end
        default: begin sr += b; si -= a; end
      endcase
    end
    if (scale != 0) begin
      sr = sr >>> 2;
      si = si >>> 2;
    end
    t = sr;
    r[15:8] = t[7:0];
    t = si;
    r[7:0] = t[7:0];
    return r;
  endfunction

  task automatic send_frame(input frame_t x, input logic [3:0] lmask,
                            input int vprob);
    bit acc;
    for (int i = 0; i < 4; i++) begin
      acc = 0;
      for (int c = 0; c < 200 && !acc; c++) begin
        @(negedge clk);
        if ($urandom_range(99) < vprob) begin
          in_valid = 1'b1;
          in_data  = x[i];
          in_last  = lmask[i];
        end else begin
          in_valid = 1'b0;
          in_data  = 16'($urandom);
          in_last  = 1'($urandom);
        end
        acc = in_valid && i_ready1;
        @(posedge clk);
        #1;
        if (acc) begin
          chk("ferr1", 32'(o1_ferr), 32'(lmask[i] != (i == 3)));
          chk("ferr0", 32'(o0_ferr), 32'(lmask[i] != (i == 3)));
        end
      end
      if (!acc) chk("tx_timeout", 32'd0, 32'd1);
    end
    @(negedge clk);
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic recv_beats(input frame_t x, input int nb, input int rprob,
                            input int stall_n);
    bit got, hold;
    int stall;
    logic [15:0] hd1, hd0;
    hold = 0;
    for (int n = 0; n < nb; n++) begin
      got   = 0;
      stall = (n == stall_n) ? 3 : 0;
      for (int c = 0; c < 200 && !got; c++) begin
        @(negedge clk);
        if (hold) begin
          chk("hold1", 32'(o1_data), 32'(hd1));
          chk("hold0", 32'(o0_data), 32'(hd0));
        end
        hold = 0;
        if (o1_valid && stall > 0) begin
          out_ready = 1'b0;
          stall--;
        end else begin
          out_ready = ($urandom_range(99) < rprob);
        end
        if (o1_valid) begin
          if (!out_ready) begin
            hold = 1;
            hd1  = o1_data;
            hd0  = o0_data;
            chk("stall_inrdy1", 32'(i_ready1), 32'd0);
            chk("stall_inrdy0", 32'(i_ready0), 32'd0);
          end else begin
            chk("x_s1", 32'(o1_data), 32'(ref_x(x, n, 1)));
            chk("x_s0", 32'(o0_data), 32'(ref_x(x, n, 0)));
            chk("last1", 32'(o1_last), 32'(n == 3));
            chk("last0", 32'(o0_last), 32'(n == 3));
            chk("valid0", 32'(o0_valid), 32'd1);
            got = 1;
          end
        end
        @(posedge clk);
      end
      if (!got) chk("rx_timeout", 32'd0, 32'd1);
    end
  endtask

  task automatic run_frame(input frame_t x, input logic [3:0] lmask,
                           input int vprob, input int rprob,
                           input int stall_n);
    fork
      send_frame(x, lmask, vprob);
      recv_beats(x, 4, rprob, stall_n);
    join
  endtask

  frame_t fx;

  initial begin
    rst       = 1'b1;
    in_valid  = 1'b0;
    in_last   = 1'b0;
    in_data   = '0;
    out_ready = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_inrdy", 32'(i_ready1), 32'd0);
    chk("rst_valid", 32'(o1_valid), 32'd0);
    chk("rst_data", 32'(o1_data), 32'd0);
    chk("rst_last", 32'(o1_last), 32'd0);
    chk("rst_ferr", 32'(o1_ferr), 32'd0);
    rst = 1'b0;
    @(negedge clk);
    chk("post_rst_inrdy", 32'(i_ready1), 32'd1);

    fx = '{16'h0400, 16'h0000, 16'h0000, 16'h0000};
    run_frame(fx, 4'b1000, 100, 100, -1);
    fx = '{16'h0000, 16'h0400, 16'h0000, 16'h0000};
    run_frame(fx, 4'b1000, 100, 100, -1);
    fx = '{16'h0100, 16'h0000, 16'h0000, 16'h0000};
    run_frame(fx, 4'b1000, 100, 100, -1);
    fx = '{16'hFF00, 16'h0000, 16'h0000, 16'h0000};
    run_frame(fx, 4'b1000, 100, 100, -1);
    fx = '{16'h8000, 16'h8000, 16'h8000, 16'h8000};
    run_frame(fx, 4'b1000, 100, 100, -1);

    fx = '{16'h1234, 16'hF00D, 16'h7F80, 16'h0C3A};
    run_frame(fx, 4'b1000, 60, 100, 1);
    fx = '{16'h7F7F, 16'h8080, 16'h7F80, 16'h807F};
    run_frame(fx, 4'b1100, 100, 100, -1);

    fx = '{16'h2211, 16'h4433, 16'h6655, 16'h8877};
    send_frame(fx, 4'b1000, 100);
    recv_beats(fx, 2, 100, -1);
    #1 rst = 1'b1;
    #1;
    chk("midrst_valid1", 32'(o1_valid), 32'd0);
    chk("midrst_valid0", 32'(o0_valid), 32'd0);
    chk("midrst_inrdy", 32'(i_ready1), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    fx = '{16'h0102, 16'hFEFD, 16'h3040, 16'hC0B0};
    run_frame(fx, 4'b1000, 100, 100, -1);

    for (int f = 0; f < 24; f++) begin
      for (int k = 0; k < 4; k++) fx[k] = 16'($urandom);
      run_frame(fx,
                ($urandom_range(3) == 0) ? 4'($urandom) : 4'b1000,
                $urandom_range(100, 40), $urandom_range(100, 30),
                ($urandom_range(3) == 0) ? int'($urandom_range(3)) : -1);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
